conv_post_pool: RTL and testbench

CONV_POST_POOL -- requirements
Module: conv_post_pool

---
 rtl/conv_post_pool.sv | 86 ++++++++
 tb/tb_conv_post_pool.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv_post_pool.sv
// conv_post_pool: 3-stage bias+ReLU+requantise+2x2 max-pool pipeline with per-set output counting; ports clk, srst, mode, set, bias_data, psum_valid, psum_data -> out_valid, out_data, out_set, set_done; define CONV_POST_ROUND_EN for round-half-up requantisation
module conv_post_pool #(
  parameter int PSUM_W = 16,
  parameter int OUT_W = 8,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT = 4,
  parameter int CONV1_OUTS = 196,
  parameter int CONV2_OUTS = 25
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [1:0]            mode,
  input  logic [7:0]            set,
  input  logic signed [3:0]     bias_data,
  input  logic                  psum_valid,
  input  logic [4*PSUM_W-1:0]   psum_data,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic [7:0]            out_set,
  output logic                  set_done
);
  localparam int SW = PSUM_W + 2;
  localparam int CW = $clog2((CONV1_OUTS > CONV2_OUTS ? CONV1_OUTS : CONV2_OUTS) + 1);
  localparam logic [CW-1:0] LIM1 = CW'(CONV1_OUTS);
  localparam logic [CW-1:0] LIM2 = CW'(CONV2_OUTS);
  localparam logic [SW-1:0] MAXV = SW'((1 << OUT_W) - 1);
`ifdef CONV_POST_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (OUT_SHIFT - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  logic                 v1, v2, accept;
  logic signed [SW-1:0] s1 [4];
  logic [OUT_W-1:0]     a2 [4];
  logic [OUT_W-1:0]     mx;
  logic [1:0]           m1, m2, mode_q;
  logic [7:0]           set1, set2;
  logic [CW-1:0]        cnt, base, nxt, lim;

  function automatic logic [OUT_W-1:0] act(input logic signed [SW-1:0] s);
    logic [SW-1:0] r;
    r = s[SW-1] ? '0 : ($unsigned(s) + RND) >> OUT_SHIFT;
    return r > MAXV ? MAXV[OUT_W-1:0] : r[OUT_W-1:0];
  endfunction

  always_comb begin
    accept = psum_valid && (mode == 2'd1 || mode == 2'd2);
    mx = a2[0];
    for (int i = 1; i < 4; i++) mx = a2[i] > mx ? a2[i] : mx;
    lim = m2 == 2'd1 ? LIM1 : LIM2;
    // a mode change restarts counting for every output from this edge on
    base = mode != mode_q ? '0 : cnt;
    nxt = base + CW'(1);
  end

  always_ff @(posedge clk) begin
    m1 <= mode;
    set1 <= set;
    for (int i = 0; i < 4; i++) s1[i] <= SW'($signed(psum_data[i*PSUM_W +: PSUM_W])) + (SW'(bias_data) <<< BIAS_SHIFT);
    m2 <= m1;
    set2 <= set1;
    for (int i = 0; i < 4; i++) a2[i] <= act(s1[i]);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_set <= '0;
      set_done <= 1'b0;
      cnt <= '0;
      mode_q <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      out_valid <= v2;
      out_data <= mx;
      out_set <= set2;
      set_done <= v2 && nxt == lim;
      cnt <= v2 ? (nxt == lim ? '0 : nxt) : base;
      mode_q <= mode;
    end
  end
endmodule

// File: tb/tb_conv_post_pool.sv
// tb_conv_post_pool: table-driven and randomized checks of conv_post_pool against an arithmetic reference model
module tb_conv_post_pool;
  logic clk = 1'b0;
  logic srst, psum_valid, out_valid, set_done;
  logic [1:0] mode;
  logic [7:0] set, out_set;
  logic signed [3:0] bias_data;
  logic [63:0] psum_data;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  conv_post_pool dut (
    .clk(clk), .srst(srst), .mode(mode), .set(set), .bias_data(bias_data),
    .psum_valid(psum_valid), .psum_data(psum_data), .out_valid(out_valid),
    .out_data(out_data), .out_set(out_set), .set_done(set_done)
  );

  typedef struct {logic v; int data; int st; logic done;} exp_t;
  typedef struct {int m; int b; int l0; int l1; int l2; int l3; int exp;} vec_t;
  exp_t q[$];
  vec_t tbl[5];
  int n = 0, bad = 0, cnt = 0, cur_mode = 0;
  int lanes[4];

  function automatic int model(int b);
    int best = 0, v;
    for (int i = 0; i < 4; i++) begin
      v = lanes[i] + b * 16;
      if (v < 0) v = 0;
`ifdef CONV_POST_ROUND_EN
      v = v + 8;
`endif
      v = v / 16;
      if (v > 255) v = 255;
      if (v > best) best = v;
    end
    return best;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("out_valid", int'(out_valid), int'(e.v));
    if (e.v) begin
      chk("out_data", int'(out_data), e.data);
      chk("out_set", int'(out_set), e.st);
      chk("set_done", int'(set_done), int'(e.done));
    end else chk("set_done_idle", int'(set_done), 0);
  endtask

  task automatic apply(input logic v, input int st, input int b, input int exp);
    exp_t e;
    mode = 2'(cur_mode);
    psum_valid = v;
    set = 8'(st);
    bias_data = 4'(b);
    for (int i = 0; i < 4; i++) psum_data[i*16 +: 16] = 16'(lanes[i]);
    e.v = v && (cur_mode == 1 || cur_mode == 2);
    e.data = exp < 0 ? model(b) : exp;
    e.st = st & 255;
    e.done = 1'b0;
    if (e.v) begin
      cnt++;
      e.done = cnt == (cur_mode == 1 ? 196 : 25);
      if (e.done) cnt = 0;
    end
    q.push_back(e);
    tick();
  endtask

  task automatic idle(input int k);
    repeat (k) apply(1'b0, 0, 0, 0);
  endtask

  task automatic set_mode(input int m);
    idle(3);
    if (m != cur_mode) cnt = 0;
    cur_mode = m;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) lanes[i] = int'($signed(16'($urandom)));
  endtask

  task automatic do_reset();
    exp_t e;
    srst = 1'b1;
    psum_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_set", int'(out_set), 0);
    chk("rst_set_done", int'(set_done), 0);
    srst = 1'b0;
    psum_valid = 1'b0;
    q.delete();
    e = '{1'b0, 0, 0, 1'b0};
    q.push_back(e);
    q.push_back(e);
    cnt = 0;
  endtask

  initial begin
    mode = 2'd0;
    set = 8'd0;
    bias_data = 4'd0;
    psum_data = '0;
    do_reset();
    do_reset();
`ifdef CONV_POST_ROUND_EN
    tbl[0] = '{1, 3, 140, -50, 20, 0, 12};
`else
    tbl[0] = '{1, 3, 140, -50, 20, 0, 11};
`endif
    tbl[1] = '{2, 7, 32767, 32767, 32767, 32767, 255};
    tbl[2] = '{1, -8, 100, 100, 100, 100, 0};
    tbl[3] = '{2, 0, 16, 32, 48, -1, 3};
    tbl[4] = '{1, 0, 4095, 0, 0, -32768, 255};
    for (int k = 0; k < 5; k++) begin
      set_mode(tbl[k].m);
      lanes = '{tbl[k].l0, tbl[k].l1, tbl[k].l2, tbl[k].l3};
      apply(1'b1, 8'hA0 + k, tbl[k].b, tbl[k].exp);
    end
    for (int r = 0; r < 2; r++) begin
      set_mode(1);
      repeat (2 * 196) begin
        rand_lanes();
        apply(1'b1, int'($urandom_range(255)), int'($signed(4'($urandom))), -1);
      end
      set_mode(2);
      repeat (2 * 25) begin
        rand_lanes();
        apply(1'b1, int'($urandom_range(255)), int'($signed(4'($urandom))), -1);
      end
    end
    set_mode(0);
    repeat (10) begin rand_lanes(); apply(1'b1, 1, 1, -1); end
    set_mode(3);
    repeat (10) begin rand_lanes(); apply(1'b1, 3, 1, -1); end
    for (int m = 1; m <= 2; m++) begin
      set_mode(m);
      repeat (300) begin
        rand_lanes();
        apply(1'($urandom_range(1)), int'($urandom_range(255)), int'($signed(4'($urandom))), -1);
      end
    end
    set_mode(1);
    rand_lanes();
    apply(1'b1, 5, 2, -1);
    rand_lanes();
    apply(1'b1, 6, 2, -1);
    do_reset();
    idle(6);
    repeat (196) begin
      rand_lanes();
      apply(1'b1, 9, int'($signed(4'($urandom))), -1);
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
